// File: rtl/key_tick_frontend.sv
// key_tick_frontend: 1 kHz timebase strobes plus synchronised, debounced and
// optionally auto-repeating push-button front end for the digital clock.
module key_tick_frontend #(
   parameter int unsigned CLK_HZ          = 1000,
   parameter int unsigned DEBOUNCE_MS     = 20,
   parameter int unsigned REPEAT_DELAY_MS = 500,
   parameter int unsigned REPEAT_RATE_MS  = 100,
   parameter logic [2:0]  REPEAT_EN       = 3'b010,
   parameter logic [2:0]  KEY_ACTIVE_LOW  = 3'b100
) (
   input  logic       clk_1khz,
   input  logic       clr,
   input  logic       button_1,
   input  logic       button_2,
   input  logic       button_3_raw,
   output logic       tick_1hz,
   output logic       tick_4hz,
   output logic       blink,
   output logic [2:0] key_level,
   output logic [2:0] key_press,
   output logic [2:0] key_release
);

   localparam int unsigned QTR    = CLK_HZ / 4;
   localparam int          CNT_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int          DC_W   = $clog2(DEBOUNCE_MS) + 1;
   localparam int unsigned RC_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ?
                                    REPEAT_DELAY_MS : REPEAT_RATE_MS;
   localparam int          RC_W   = $clog2(RC_MAX) + 1;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_Q1   = CNT_W'(QTR - 1);
   localparam logic [CNT_W-1:0] CNT_Q2   = CNT_W'(2 * QTR - 1);
   localparam logic [CNT_W-1:0] CNT_Q3   = CNT_W'(3 * QTR - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

   localparam logic [DC_W-1:0]  DC_ONE   = DC_W'(1);
   localparam logic [DC_W-1:0]  DC_TERM  = DC_W'(DEBOUNCE_MS - 1);

   localparam logic [RC_W-1:0]  RC_ONE        = RC_W'(1);
   localparam logic [RC_W-1:0]  RC_DELAY_TERM = RC_W'(REPEAT_DELAY_MS - 1);
   localparam logic [RC_W-1:0]  RC_RATE_TERM  = RC_W'(REPEAT_RATE_MS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_RPT} rpt_state_t;

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_tick_1hz;
   logic             r_tick_4hz;
   logic             r_blink;

   assign w_cnt_nxt = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;

   // Strobes are registered from the next count so they are high while r_cnt
   // sits on the terminal values; blink flips as each 4 Hz strobe cycle ends.
   always_ff @(posedge clk_1khz) begin
      if (clr) begin
         r_cnt      <= '0;
         r_tick_1hz <= 1'b0;
         r_tick_4hz <= 1'b0;
         r_blink    <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_tick_1hz <= (w_cnt_nxt == CNT_LAST);
         r_tick_4hz <= (w_cnt_nxt == CNT_Q1) || (w_cnt_nxt == CNT_Q2) ||
                       (w_cnt_nxt == CNT_Q3) || (w_cnt_nxt == CNT_LAST);
         if (r_tick_4hz) begin
            r_blink <= ~r_blink;
         end
      end
   end

   assign tick_1hz = r_tick_1hz;
   assign tick_4hz = r_tick_4hz;
   assign blink    = r_blink;

   logic [2:0] w_raw;
   assign w_raw = {button_3_raw, button_2, button_1} ^ KEY_ACTIVE_LOW;

   for (genvar k = 0; k < 3; k++) begin : g_key
      logic            r_sync_p0;
      logic            r_sync_p1;
      logic [DC_W-1:0] r_dc;
      logic            r_level;
      logic            r_press;
      logic            r_release;
      logic            w_flip;
      logic            w_rise;
      logic            w_fall;

      assign w_flip = (r_sync_p1 != r_level) && (r_dc == DC_TERM);
      assign w_rise = w_flip & ~r_level;
      assign w_fall = w_flip &  r_level;

      always_ff @(posedge clk_1khz) begin
         if (clr) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
            r_dc      <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b0;
         end else begin
            r_sync_p0 <= w_raw[k];
            r_sync_p1 <= r_sync_p0;
            r_release <= w_fall;
            if (r_sync_p1 == r_level) begin
               r_dc <= '0;
            end else if (w_flip) begin
               r_level <= ~r_level;
               r_dc    <= '0;
            end else begin
               r_dc <= r_dc + DC_ONE;
            end
         end
      end

      if (REPEAT_EN[k]) begin : g_rpt
         rpt_state_t      r_state;
         logic [RC_W-1:0] r_rc;

         // A debounced release always wins over a repeat at terminal count.
         always_ff @(posedge clk_1khz) begin
            if (clr) begin
               r_state <= ST_IDLE;
               r_rc    <= '0;
               r_press <= 1'b0;
            end else begin
               r_press <= w_rise;
               if (w_fall) begin
                  r_state <= ST_IDLE;
                  r_rc    <= '0;
               end else begin
                  case (r_state)
                     ST_IDLE: begin
                        if (w_rise) begin
                           r_state <= ST_DELAY;
                           r_rc    <= '0;
                        end
                     end
                     ST_DELAY: begin
                        if (r_rc == RC_DELAY_TERM) begin
                           r_press <= 1'b1;
                           r_state <= ST_RPT;
                           r_rc    <= '0;
                        end else begin
                           r_rc <= r_rc + RC_ONE;
                        end
                     end
                     ST_RPT: begin
                        if (r_rc == RC_RATE_TERM) begin
                           r_press <= 1'b1;
                           r_rc    <= '0;
                        end else begin
                           r_rc <= r_rc + RC_ONE;
                        end
                     end
                     default: begin
                        r_state <= ST_IDLE;
                        r_rc    <= '0;
                     end
                  endcase
               end
            end
         end
      end else begin : g_norpt
         always_ff @(posedge clk_1khz) begin
            if (clr) begin
               r_press <= 1'b0;
            end else begin
               r_press <= w_rise;
            end
         end
      end

      assign key_level[k]   = r_level;
      assign key_press[k]   = r_press;
      assign key_release[k] = r_release;
   end

endmodule

// File: tb/tb_key_tick_frontend.sv
// Bench for key_tick_frontend: directed scenarios with literal expectations
// plus randomized button/clr activity checked every cycle against a model.
module tb_key_tick_frontend;

   localparam int         CLK_HZ = 1000;
   localparam int         Q      = CLK_HZ / 4;
   localparam int         DEB    = 20;
   localparam int         RDLY   = 500;
   localparam int         RRATE  = 100;
   localparam logic [2:0] REN    = 3'b010;
   localparam logic [2:0] ALOW   = 3'b100;

   logic       clk_1khz = 1'b0;
   logic       clr;
   logic       button_1;
   logic       button_2;
   logic       button_3_raw;
   logic       tick_1hz;
   logic       tick_4hz;
   logic       blink;
   logic [2:0] key_level;
   logic [2:0] key_press;
   logic [2:0] key_release;

   int n_chk = 0;
   int n_pass = 0;

   key_tick_frontend dut (
      .clk_1khz     (clk_1khz),
      .clr          (clr),
      .button_1     (button_1),
      .button_2     (button_2),
      .button_3_raw (button_3_raw),
      .tick_1hz     (tick_1hz),
      .tick_4hz     (tick_4hz),
      .blink        (blink),
      .key_level    (key_level),
      .key_press    (key_press),
      .key_release  (key_release)
   );

   always #5 clk_1khz = ~clk_1khz;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                    name, act, act, exp, exp, $time);
   endtask

   // Reference model: n = edges since reset, keys tracked by how long the
   // synchronised input has disagreed with the debounced level, and repeat
   // pulses placed arithmetically relative to the press edge.
   bit         m_on = 1'b0;
   int         m_n;
   logic [2:0] m_d0, m_d1, m_lvl, m_prs, m_rel;
   int         m_run [3];
   int         m_pe  [3];

   always @(posedge clk_1khz) begin
      logic [2:0] raw;
      logic       s;
      int         d;
      if (clr) begin
         m_on  = 1'b1;
         m_n   = 0;
         m_d0  = '0;
         m_d1  = '0;
         m_lvl = '0;
         m_prs = '0;
         m_rel = '0;
         for (int k = 0; k < 3; k++) begin
            m_run[k] = 0;
            m_pe[k]  = 0;
         end
      end else if (m_on) begin
         raw = {button_3_raw, button_2, button_1} ^ ALOW;
         m_n++;
         for (int k = 0; k < 3; k++) begin
            s        = m_d1[k];
            m_d1[k]  = m_d0[k];
            m_d0[k]  = raw[k];
            m_prs[k] = 1'b0;
            m_rel[k] = 1'b0;
            if (s != m_lvl[k]) m_run[k]++;
            else m_run[k] = 0;
            if (m_run[k] == DEB) begin
               m_run[k] = 0;
               m_lvl[k] = ~m_lvl[k];
               if (m_lvl[k]) begin
                  m_prs[k] = 1'b1;
                  m_pe[k]  = m_n;
               end else begin
                  m_rel[k] = 1'b1;
               end
            end else if (m_lvl[k] && REN[k]) begin
               d = m_n - m_pe[k];
               if (d >= RDLY && ((d - RDLY) % RRATE) == 0) m_prs[k] = 1'b1;
            end
         end
      end
   end

   always @(negedge clk_1khz) begin
      bit e1, e4, eb;
      if (m_on) begin
         e1 = ((m_n % CLK_HZ) == CLK_HZ - 1);
         e4 = ((m_n % Q) == Q - 1);
         eb = (((m_n / Q) % 2) == 1);
         chk("cycle {t1hz,t4hz,blink,level,press,release}",
             {20'd0, tick_1hz, tick_4hz, blink, key_level, key_press, key_release},
             {20'd0, e1, e4, eb, m_lvl, m_prs, m_rel});
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: cycle budget exceeded");
      $fatal(1, "watchdog");
   end

   task automatic set_key(input int k, input logic v);
      case (k)
         0:       button_1 = v;
         1:       button_2 = v;
         default: button_3_raw = ~v;
      endcase
   endtask

   function automatic logic key_now(input int k);
      case (k)
         0:       return button_1;
         1:       return button_2;
         default: return ~button_3_raw;
      endcase
   endfunction

   // Returns j = number of edges after the current negedge at which any masked
   // bit of press (rel=0) or release (rel=1) is first seen; -1 on timeout.
   task automatic wait_bits(input logic [2:0] mask, input bit rel, input int limit,
                            output int j, output logic [2:0] seen);
      logic [2:0] v;
      j    = -1;
      seen = '0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk_1khz);
         v = rel ? key_release : key_press;
         if ((v & mask) != 3'b000) begin
            j    = i;
            seen = v;
            break;
         end
      end
   endtask

   task automatic count_press(input logic [2:0] mask, input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk_1khz);
         if ((key_press & mask) != 3'b000) cnt++;
      end
   endtask

   initial begin
      int         j, cnt, t1n, t1pos, t4n, bt, pc, npos, kk;
      int         t4pos [4];
      int         rpos  [8];
      int         rexp  [5];
      logic       pb;
      logic [2:0] seen;

      clr          = 1'b1;
      button_1     = 1'b0;
      button_2     = 1'b0;
      button_3_raw = 1'b1;
      repeat (3) @(negedge clk_1khz);
      clr = 1'b0;

      // Timebase over one full second, no key activity.
      t1n = 0; t1pos = -1; t4n = 0; bt = 0; pc = 0; pb = blink;
      for (int i = 0; i < 4; i++) t4pos[i] = -1;
      for (int c = 0; c <= 1000; c++) begin
         if (c == 0)
            chk("reset_outputs",
                {20'd0, tick_1hz, tick_4hz, blink, key_level, key_press, key_release}, 0);
         if (tick_1hz) begin t1n++; t1pos = c; end
         if (tick_4hz) begin
            if (t4n < 4) t4pos[t4n] = c;
            t4n++;
         end
         if (blink != pb) bt++;
         pb = blink;
         if ((key_press | key_release) != 3'b000) pc++;
         if (c < 1000) @(negedge clk_1khz);
      end
      chk("t1_tick1hz_count", t1n, 1);
      chk("t1_tick1hz_cnt", t1pos, 999);
      chk("t1_tick4hz_count", t4n, 4);
      chk("t1_tick4hz_pos0", t4pos[0], 249);
      chk("t1_tick4hz_pos1", t4pos[1], 499);
      chk("t1_tick4hz_pos2", t4pos[2], 749);
      chk("t1_tick4hz_pos3", t4pos[3], 999);
      chk("t1_blink_toggles", bt, 4);
      chk("t1_key_pulses", pc, 0);

      // Key 0 press, no auto-repeat.
      button_1 = 1'b1;
      wait_bits(3'b001, 1'b0, 40, j, seen);
      chk("t2_press_latency", j, 21);
      chk("t2_level", int'(key_level[0]), 1);
      @(negedge clk_1khz);
      chk("t2_press_one_cycle", int'(key_press[0]), 0);
      count_press(3'b001, 700, cnt);
      chk("t2_no_repeat", cnt, 0);
      button_1 = 1'b0;
      wait_bits(3'b001, 1'b1, 40, j, seen);
      chk("t2_release_latency", j, 21);

      // Key 1 bounce then stable press.
      for (int b = 0; b < 8; b++) begin
         button_2 = ((b % 4) < 2);
         @(negedge clk_1khz);
      end
      button_2 = 1'b1;
      wait_bits(3'b010, 1'b0, 40, j, seen);
      chk("t3_bounce_press_latency", j, 21);

      // Key 1 auto-repeat while held.
      rexp[0] = 500; rexp[1] = 600; rexp[2] = 700; rexp[3] = 800; rexp[4] = 900;
      npos = 0;
      for (int i = 0; i < 8; i++) rpos[i] = -1;
      for (int i = 1; i < 1000; i++) begin
         @(negedge clk_1khz);
         if (key_press[1]) begin
            if (npos < 8) rpos[npos] = i;
            npos++;
         end
      end
      chk("t4_repeat_count", npos, 5);
      for (int i = 0; i < 5; i++) chk($sformatf("t4_repeat_pos%0d", i), rpos[i], rexp[i]);
      button_2 = 1'b0;
      wait_bits(3'b010, 1'b1, 40, j, seen);
      chk("t4_release_latency", j, 21);
      count_press(3'b010, 700, cnt);
      chk("t4_no_press_after_release", cnt, 0);

      // Key 2 (active-low) held through clr, then a one-cycle clr mid-hold.
      clr          = 1'b1;
      button_3_raw = 1'b0;
      pc = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_1khz);
         if ((key_press | key_level) != 3'b000) pc++;
      end
      chk("t5_quiet_during_clr", pc, 0);
      clr = 1'b0;
      wait_bits(3'b100, 1'b0, 40, j, seen);
      chk("t5_press_after_clr", j, 21);
      repeat (30) @(negedge clk_1khz);
      clr = 1'b1;
      @(negedge clk_1khz);
      chk("t5_level_cleared", {29'd0, key_level}, 0);
      clr = 1'b0;
      wait_bits(3'b100, 1'b0, 40, j, seen);
      chk("t5_fresh_press", j, 21);
      button_3_raw = 1'b1;
      wait_bits(3'b100, 1'b1, 40, j, seen);
      chk("t5_release_latency", j, 21);

      // Simultaneous press and release of keys 0 and 1.
      button_1 = 1'b1;
      button_2 = 1'b1;
      wait_bits(3'b011, 1'b0, 40, j, seen);
      chk("t6_press_latency", j, 21);
      chk("t6_press_both", {29'd0, seen}, 3);
      repeat (50) @(negedge clk_1khz);
      button_1 = 1'b0;
      button_2 = 1'b0;
      wait_bits(3'b011, 1'b1, 40, j, seen);
      chk("t6_release_both", {29'd0, seen}, 3);

      // Randomized activity, checked by the per-cycle model comparison.
      for (int it = 0; it < 120; it++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r == 0) begin
            clr = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk_1khz);
            clr = 1'b0;
         end else begin
            kk = $urandom_range(0, 2);
            set_key(kk, ~key_now(kk));
            if (r < 5) repeat ($urandom_range(1, 5)) @(negedge clk_1khz);
            else repeat ($urandom_range(10, 150)) @(negedge clk_1khz);
         end
      end
      repeat (30) @(negedge clk_1khz);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
